// File: rtl/ysyx_22050612_pkg.sv
// Shared decode constants for the ysyx_22050612 decode stage: instruction
// format codes, RV32I/RV64I major opcodes and the opcode classifier.
package ysyx_22050612_pkg;

    // Instruction format codes carried on out_itype
    localparam logic [2:0] IT_R   = 3'd0;
    localparam logic [2:0] IT_I   = 3'd1;
    localparam logic [2:0] IT_S   = 3'd2;
    localparam logic [2:0] IT_B   = 3'd3;
    localparam logic [2:0] IT_U   = 3'd4;
    localparam logic [2:0] IT_J   = 3'd5;
    localparam logic [2:0] IT_ILL = 3'd6;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP32      = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Map a major opcode to its format. Every listed opcode ends in 2'b11,
    // so compressed encodings fall through to IT_ILL on their own.
    // The word-sized opcodes only exist on RV64.
    function automatic logic [2:0] classify(input logic [6:0] opcode, input logic rv64);
        logic [2:0] t;
        t = IT_ILL;
        case (opcode)
            OP_LUI, OP_AUIPC:            t = IT_U;
            OP_JAL:                      t = IT_J;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_SYSTEM:                   t = IT_I;
            OP_BRANCH:                   t = IT_B;
            OP_STORE:                    t = IT_S;
            OP:                          t = IT_R;
            OP_IMM32:                    t = rv64 ? IT_I : IT_ILL;
            OP32:                        t = rv64 ? IT_R : IT_ILL;
            default:                     t = IT_ILL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ysyx_22050612_imm_gen.sv
// Immediate generator: builds the immediate selected by itype from the raw
// instruction word and sign-extends it to XLEN. R and ILL yield zero.
module ysyx_22050612_imm_gen
    import ysyx_22050612_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      itype,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sel;

    // Every format fits in 32 bits, so build them at 32 and widen once
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Select the immediate matching the decoded format
    always_comb begin
        imm_sel = 32'd0;
        case (itype)
            IT_I:    imm_sel = imm_i;
            IT_S:    imm_sel = imm_s;
            IT_B:    imm_sel = imm_b;
            IT_U:    imm_sel = imm_u;
            IT_J:    imm_sel = imm_j;
            default: imm_sel = 32'd0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_rv64
            assign imm = {{32{imm_sel[31]}}, imm_sel};
        end else begin : g_rv32
            assign imm = imm_sel;
        end
    endgenerate

endmodule

// File: rtl/ysyx_22050612_idu_stage.sv
// Instruction decode stage: classifies and decodes {pc,inst} before
// registering, and holds results in a main register M plus a skid register K
// so in_ready is a pure flop and throughput stays at one per cycle.
module ysyx_22050612_idu_stage
    import ysyx_22050612_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_itype,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [6:0]      out_opcode,
    output logic            out_rd_wen,
    output logic            out_is_ebreak,
    output logic            out_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      itype;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [6:0]      opcode;
        logic            rd_wen;
        logic            is_ebreak;
        logic            illegal;
    } bundle_t;

    bundle_t         dec_bundle;
    bundle_t         m_reg;
    bundle_t         k_reg;
    logic            m_valid_reg;
    logic            k_valid_reg;
    logic [2:0]      dec_itype;
    logic [XLEN-1:0] dec_imm;
    logic            accept;
    logic            m_free;

    assign dec_itype = classify(in_inst[6:0], XLEN == 64);

    ysyx_22050612_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst  (in_inst),
        .itype (dec_itype),
        .imm   (dec_imm)
    );

    // Full decode of the incoming word, ready to be captured into M or K
    always_comb begin
        dec_bundle           = '0;
        dec_bundle.pc        = in_pc;
        dec_bundle.itype     = dec_itype;
        dec_bundle.imm       = dec_imm;
        dec_bundle.rd        = in_inst[11:7];
        dec_bundle.rs1       = in_inst[19:15];
        dec_bundle.rs2       = in_inst[24:20];
        dec_bundle.funct3    = in_inst[14:12];
        dec_bundle.funct7    = in_inst[31:25];
        dec_bundle.opcode    = in_inst[6:0];
        dec_bundle.rd_wen    = ((dec_itype == IT_R) || (dec_itype == IT_I) ||
                                (dec_itype == IT_U) || (dec_itype == IT_J)) &&
                               (in_inst[11:7] != 5'd0);
        dec_bundle.is_ebreak = (in_inst == INST_EBREAK);
        dec_bundle.illegal   = (dec_itype == IT_ILL);
    end

    // in_ready only reflects the skid register, never out_ready
    assign in_ready = !k_valid_reg;
    assign accept   = in_valid && in_ready;
    // M can take new data when empty or when it is being consumed this cycle
    assign m_free   = !m_valid_reg || out_ready;

    // M/K skid control; K is only ever occupied while M is occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            k_valid_reg <= 1'b0;
            m_reg       <= '0;
            k_reg       <= '0;
        end else if (flush) begin
            m_valid_reg <= 1'b0;
            k_valid_reg <= 1'b0;
        end else if (m_free) begin
            if (k_valid_reg) begin
                m_reg       <= k_reg;
                m_valid_reg <= 1'b1;
                k_valid_reg <= 1'b0;
            end else if (accept) begin
                m_reg       <= dec_bundle;
                m_valid_reg <= 1'b1;
            end else begin
                m_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            k_reg       <= dec_bundle;
            k_valid_reg <= 1'b1;
        end
    end

    assign out_valid     = m_valid_reg;
    assign out_pc        = m_reg.pc;
    assign out_itype     = m_reg.itype;
    assign out_imm       = m_reg.imm;
    assign out_rd        = m_reg.rd;
    assign out_rs1       = m_reg.rs1;
    assign out_rs2       = m_reg.rs2;
    assign out_funct3    = m_reg.funct3;
    assign out_funct7    = m_reg.funct7;
    assign out_opcode    = m_reg.opcode;
    assign out_rd_wen    = m_reg.rd_wen;
    assign out_is_ebreak = m_reg.is_ebreak;
    assign out_illegal   = m_reg.illegal;

endmodule

// File: tb/tb_ysyx_22050612_idu_stage.sv
// Bench for the decode stage: an RV64 and an RV32 instance share stimulus;
// a queue of expected bundles is filled on accept and drained on output.
module tb_ysyx_22050612_idu_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;

    logic        in_ready, out_valid, out_rd_wen, out_is_ebreak, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [2:0]  out_itype, out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [6:0]  out_funct7, out_opcode;

    logic        in_ready_32, out_valid_32, out_rd_wen_32, out_is_ebreak_32, out_illegal_32;
    logic [63:0] out_pc_32;
    logic [31:0] out_imm_32;
    logic [2:0]  out_itype_32, out_funct3_32;
    logic [4:0]  out_rd_32, out_rs1_32, out_rs2_32;
    logic [6:0]  out_funct7_32, out_opcode_32;

    ysyx_22050612_idu_stage #(.XLEN(64), .PC_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_itype(out_itype), .out_imm(out_imm), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_opcode(out_opcode), .out_rd_wen(out_rd_wen), .out_is_ebreak(out_is_ebreak),
        .out_illegal(out_illegal)
    );

    ysyx_22050612_idu_stage #(.XLEN(32), .PC_W(64)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_32), .out_ready(out_ready),
        .out_pc(out_pc_32), .out_itype(out_itype_32), .out_imm(out_imm_32), .out_rd(out_rd_32),
        .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_funct3(out_funct3_32),
        .out_funct7(out_funct7_32), .out_opcode(out_opcode_32), .out_rd_wen(out_rd_wen_32),
        .out_is_ebreak(out_is_ebreak_32), .out_illegal(out_illegal_32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  itype;
        logic [63:0] imm;
        logic [2:0]  itype32;
        logic [31:0] imm32;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic        wen, ebreak, ill, ill32;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int   total = 0;
    int   bad = 0;
    int   n_out = 0;

    function automatic logic [2:0] ref_type(input logic [31:0] i, input bit rv64);
        case (i[6:0])
            7'h37, 7'h17: return 3'd4;
            7'h6f:        return 3'd5;
            7'h67, 7'h03, 7'h13, 7'h73: return 3'd1;
            7'h63:        return 3'd3;
            7'h23:        return 3'd2;
            7'h33:        return 3'd0;
            7'h1b:        return rv64 ? 3'd1 : 3'd6;
            7'h3b:        return rv64 ? 3'd0 : 3'd6;
            default:      return 3'd6;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
        case (t)
            3'd1: return {{52{i[31]}}, i[31:20]};
            3'd2: return {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: return {{32{i[31]}}, i[31:12], 12'b0};
            3'd5: return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 64'd0;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [63:0] pc, input logic [31:0] i);
        exp_t e;
        logic [63:0] imm32_full;
        e.pc      = pc;
        e.itype   = ref_type(i, 1'b1);
        e.imm     = ref_imm(i, e.itype);
        e.itype32 = ref_type(i, 1'b0);
        imm32_full = ref_imm(i, e.itype32);
        e.imm32   = imm32_full[31:0];
        e.rd      = i[11:7];
        e.rs1     = i[19:15];
        e.rs2     = i[24:20];
        e.f3      = i[14:12];
        e.f7      = i[31:25];
        e.op      = i[6:0];
        e.wen     = (e.itype inside {3'd0, 3'd1, 3'd4, 3'd5}) && (i[11:7] != 5'd0);
        e.ebreak  = (i == 32'h0010_0073);
        e.ill     = (e.itype == 3'd6);
        e.ill32   = (e.itype32 == 3'd6);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Scoreboard: pop/compare on output handshake, push on input handshake
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
                if (sb.size() != 0) begin
                    e_pop = sb.pop_front();
                    chk("sb_pc", out_pc, e_pop.pc);
                    chk("sb_itype", 64'(out_itype), 64'(e_pop.itype));
                    chk("sb_imm", out_imm, e_pop.imm);
                    chk("sb_regs", {49'd0, out_rd, out_rs1, out_rs2},
                        {49'd0, e_pop.rd, e_pop.rs1, e_pop.rs2});
                    chk("sb_funct", {47'd0, out_funct3, out_funct7, out_opcode},
                        {47'd0, e_pop.f3, e_pop.f7, e_pop.op});
                    chk("sb_flags", {61'd0, out_rd_wen, out_is_ebreak, out_illegal},
                        {61'd0, e_pop.wen, e_pop.ebreak, e_pop.ill});
                    chk("sb32_itype", 64'(out_itype_32), 64'(e_pop.itype32));
                    chk("sb32_imm", 64'(out_imm_32), 64'(e_pop.imm32));
                    chk("sb32_illegal", 64'(out_illegal_32), 64'(e_pop.ill32));
                    chk("sb32_valid", 64'(out_valid_32), 64'd1);
                end
            end
            if (in_valid && in_ready) sb.push_back(make_exp(in_pc, in_inst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] st [4];
    int          idx;
    int          n0;
    bit          acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 64'd0; in_inst = 32'd0;
        st[0] = 32'h00a0_0093; st[1] = 32'h0141_0113;
        st[2] = 32'h01e1_8193; st[3] = 32'h0282_0213;
        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        rst = 1'b0;

        // Single instructions with a free-running sink
        send(64'h1000, 32'hfff0_0093);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_itype", 64'(out_itype), 64'd1);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_rs1", 64'(out_rs1), 64'd0);
        chk("addi_wen", 64'(out_rd_wen), 64'd1);
        send(64'h1004, 32'h0011_2623);
        chk("sw_itype", 64'(out_itype), 64'd2);
        chk("sw_imm", out_imm, 64'd12);
        chk("sw_rs", {54'd0, out_rs1, out_rs2}, {54'd0, 5'd2, 5'd1});
        chk("sw_wen", 64'(out_rd_wen), 64'd0);
        send(64'h1008, 32'hfe00_0ee3);
        chk("beq_itype", 64'(out_itype), 64'd3);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        send(64'h100c, 32'h8000_02b7);
        chk("lui_itype", 64'(out_itype), 64'd4);
        chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", 64'(out_rd), 64'd5);
        chk("lui_imm32", 64'(out_imm_32), 64'h8000_0000);
        send(64'h1010, 32'h0010_0073);
        chk("ebreak", 64'(out_is_ebreak), 64'd1);
        send(64'h1014, 32'h0000_0000);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        chk("zero_imm", out_imm, 64'd0);
        send(64'h1018, 32'h0000_003b);
        chk("op32_rv64_illegal", 64'(out_illegal), 64'd0);
        chk("op32_rv32_illegal", 64'(out_illegal_32), 64'd1);
        tick();

        // Stream of four under a three-cycle stall
        idx = 0;
        n0  = n_out;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            in_pc     = 64'h2000 + 64'(4 * idx);
            in_inst   = st[idx < 4 ? idx : 0];
            acc       = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (c == 1) chk("stall_in_ready_low", 64'(in_ready), 64'd0);
            if (c <= 2) begin
                chk("stall_hold_pc", out_pc, 64'h2000);
                chk("stall_hold_imm", out_imm, 64'd10);
                chk("stall_hold_valid", 64'(out_valid), 64'd1);
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", 64'(idx), 64'd4);
        chk("stream_outputs", 64'(n_out - n0), 64'd4);

        // Flush with M and K both full, then flush racing an accept
        out_ready = 1'b0;
        send(64'h3000, 32'h0050_0293);
        send(64'h3004, 32'h0060_0313);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_pc = 64'h3008; in_inst = 32'h0070_0393; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_pc = 64'h300c; in_inst = 32'h0080_0413; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (3) tick();
        chk("flush_no_output", 64'(n_out - n0), 64'd0);

        // Reset in the middle of a stall
        out_ready = 1'b0;
        send(64'h4000, 32'h8000_02b7);
        send(64'h4004, 32'hfe00_0ee3);
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_imm", out_imm, 64'd0);
        chk("mrst_pc", out_pc, 64'd0);
        chk("mrst_fields", {45'd0, out_itype, out_rd, out_opcode, out_rd_wen},
            64'd0);
        chk("mrst_imm32", 64'(out_imm_32), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (3) tick();
        chk("mrst_no_output", 64'(n_out - n0), 64'd0);
        chk("sb_empty_at_end", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
